deadtime_gen_mc: RTL and testbench

Multi-channel complementary dead-time generator for the gate-driver controller. It takes CH raw PWM commands and produces CH high-side/low-side gate pairs. Each pair has independent programmable rising and falling dead times, suppresses pulses shorter than the dead time, and shuts down on a latched fault. It sits between the PWM modulator and the gate-driver output pins.

---
 rtl/deadtime_pkg.sv | 13 +
 rtl/deadtime_chan.sv | 115 +++++++++++
 rtl/deadtime_gen_mc.sv | 50 +++++
 tb/tb_deadtime_gen_mc.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/deadtime_pkg.sv
// Shared types and constants for the multi-channel dead-time generator.
package deadtime_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    HS_ON = 2'd2,
    LS_ON = 2'd3
  } dt_state_e;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/deadtime_chan.sv
// One half-bridge channel: input synchronizer, dead-time FSM and registered gate drives.
module deadtime_chan
  import deadtime_pkg::*;
#(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         kill_i,
  input  logic         pwm_i,
  input  logic [N-1:0] dt_rise_i,
  input  logic [N-1:0] dt_fall_i,
  output logic         hs_o,
  output logic         ls_o,
  output logic         dt_active_o
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  pwm_q;
  dt_state_e             state_q;
  logic [N-1:0]          cnt_q;
  logic                  tgt_q;
  logic                  hs_q, ls_q, dta_q;
  logic [N-1:0]          dt_d;
  logic                  cnt_last;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_DEPTH-2:0], pwm_i};
  end

  assign pwm_q = sync_q[SYNC_DEPTH-1];

  // Dead time for a transition towards the current pwm_q level.
  assign dt_d     = pwm_q ? dt_rise_i : dt_fall_i;
  // A zero dead time latched on start still finishes after one dead cycle.
  assign cnt_last = (cnt_q[N-1:1] == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
      dta_q   <= 1'b0;
    end else if (kill_i) begin
      state_q <= IDLE;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
      dta_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= DEAD;
          tgt_q   <= pwm_q;
          cnt_q   <= dt_d;
          dta_q   <= 1'b1;
        end
        DEAD: begin
          if (pwm_q != tgt_q) begin
            tgt_q <= pwm_q;
            cnt_q <= dt_d;
          end else if (cnt_last) begin
            state_q <= tgt_q ? HS_ON : LS_ON;
            hs_q    <= tgt_q;
            ls_q    <= ~tgt_q;
            dta_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - N'(1);
          end
        end
        HS_ON: begin
          if (!pwm_q) begin
            hs_q  <= 1'b0;
            tgt_q <= 1'b0;
            cnt_q <= dt_d;
            if (dt_d == '0) begin
              state_q <= LS_ON;
              ls_q    <= 1'b1;
            end else begin
              state_q <= DEAD;
              dta_q   <= 1'b1;
            end
          end
        end
        LS_ON: begin
          if (pwm_q) begin
            ls_q  <= 1'b0;
            tgt_q <= 1'b1;
            cnt_q <= dt_d;
            if (dt_d == '0) begin
              state_q <= HS_ON;
              hs_q    <= 1'b1;
            end else begin
              state_q <= DEAD;
              dta_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          hs_q    <= 1'b0;
          ls_q    <= 1'b0;
          dta_q   <= 1'b0;
        end
      endcase
    end
  end

  assign hs_o        = hs_q;
  assign ls_o        = ls_q;
  assign dt_active_o = dta_q;

endmodule

// File: rtl/deadtime_gen_mc.sv
// CH-channel complementary dead-time generator with shared fault latch and enable gating.
module deadtime_gen_mc
  import deadtime_pkg::*;
#(
  parameter int CH = 3,
  parameter int N  = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [CH-1:0] pwm_in,
  input  logic [N-1:0]  dt_rise,
  input  logic [N-1:0]  dt_fall,
  input  logic          fault,
  input  logic          fault_clr,
  output logic [CH-1:0] hs_out,
  output logic [CH-1:0] ls_out,
  output logic [CH-1:0] dt_active,
  output logic          fault_latched
);

  logic fault_q;
  logic kill;

  // fault wins over fault_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)          fault_q <= 1'b0;
    else if (fault)     fault_q <= 1'b1;
    else if (fault_clr) fault_q <= 1'b0;
  end

  // Raw fault is included so gates drop on the very edge the fault is sampled.
  assign kill          = ~en | fault | fault_q;
  assign fault_latched = fault_q;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    deadtime_chan #(.N(N)) u_chan (
      .clk         (clk),
      .reset       (reset),
      .kill_i      (kill),
      .pwm_i       (pwm_in[g]),
      .dt_rise_i   (dt_rise),
      .dt_fall_i   (dt_fall),
      .hs_o        (hs_out[g]),
      .ls_o        (ls_out[g]),
      .dt_active_o (dt_active[g])
    );
  end

endmodule

// File: tb/tb_deadtime_gen_mc.sv
// Directed bench for deadtime_gen_mc with hand-derived edge-by-edge expectations.
module tb_deadtime_gen_mc;

  localparam int CH = 3;
  localparam int N  = 12;

  logic          clk = 1'b0;
  logic          reset, en, fault, fault_clr;
  logic [CH-1:0] pwm_in;
  logic [N-1:0]  dt_rise, dt_fall;
  logic [CH-1:0] hs_out, ls_out, dt_active;
  logic          fault_latched;

  int checks = 0;
  int errors = 0;

  deadtime_gen_mc #(.CH(CH), .N(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .pwm_in        (pwm_in),
    .dt_rise       (dt_rise),
    .dt_fall       (dt_fall),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .hs_out        (hs_out),
    .ls_out        (ls_out),
    .dt_active     (dt_active),
    .fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Shoot-through guard on every cycle.
  always @(negedge clk) chk("overlap", 32'(hs_out & ls_out), 32'd0);

  initial begin
    reset = 1'b1; en = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    pwm_in = '0; dt_rise = 12'd5; dt_fall = 12'd3;
    tick(3);
    chk("rst_hs", 32'(hs_out), 32'd0);
    chk("rst_ls", 32'(ls_out), 32'd0);
    chk("rst_dta", 32'(dt_active), 32'd0);
    chk("rst_fl", 32'(fault_latched), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("idle_dta", 32'(dt_active), 32'd0);

    // Start-up: every channel gets a dt_fall dead interval before ls.
    en = 1'b1;
    tick(1);
    chk("start_dta", 32'(dt_active), 32'h7);
    tick(2);
    chk("start_ls_lo", 32'(ls_out), 32'd0);
    tick(1);
    chk("start_ls", 32'(ls_out), 32'h7);
    chk("start_dta0", 32'(dt_active), 32'd0);

    // ch0 rise with dt_rise=5: ls falls at E2, hs at E2+5.
    pwm_in = 3'b001;
    tick(2);
    chk("r_e1_ls", 32'(ls_out), 32'h7);
    tick(1);
    chk("r_e2_ls", 32'(ls_out), 32'h6);
    chk("r_e2_dta", 32'(dt_active), 32'h1);
    tick(4);
    chk("r_e6_hs", 32'(hs_out), 32'h0);
    tick(1);
    chk("r_e7_hs", 32'(hs_out), 32'h1);
    chk("r_e7_dta", 32'(dt_active), 32'h0);

    // ch0 fall with dt_fall=3.
    pwm_in = 3'b000;
    tick(2);
    chk("f_e1_hs", 32'(hs_out), 32'h1);
    tick(1);
    chk("f_e2_hs", 32'(hs_out), 32'h0);
    chk("f_e2_ls", 32'(ls_out), 32'h6);
    tick(2);
    chk("f_e4_ls", 32'(ls_out), 32'h6);
    tick(1);
    chk("f_e5_ls", 32'(ls_out), 32'h7);

    // Zero dead time: same-edge swap, dt_active never set.
    dt_rise = '0; dt_fall = '0;
    pwm_in = 3'b010;
    tick(2);
    chk("z_e1_dta", 32'(dt_active), 32'h0);
    tick(1);
    chk("z_up_hs", 32'(hs_out), 32'h2);
    chk("z_up_ls", 32'(ls_out), 32'h5);
    chk("z_up_dta", 32'(dt_active), 32'h0);
    pwm_in = 3'b000;
    tick(3);
    chk("z_dn_hs", 32'(hs_out), 32'h0);
    chk("z_dn_ls", 32'(ls_out), 32'h7);
    chk("z_dn_dta", 32'(dt_active), 32'h0);

    // Short pulse on ch2 (4 clocks) against dt_rise=8: suppressed.
    dt_rise = 12'd8; dt_fall = 12'd3;
    pwm_in = 3'b100;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) pwm_in = 3'b000;
      tick(1);
      chk("sp_hs", 32'(hs_out), 32'h0);
      if (k == 2) chk("sp_e2_ls", 32'(ls_out), 32'h3);
      if (k == 8) begin
        chk("sp_e8_ls", 32'(ls_out), 32'h3);
        chk("sp_e8_dta", 32'(dt_active), 32'h4);
      end
      if (k == 9) begin
        chk("sp_e9_ls", 32'(ls_out), 32'h7);
        chk("sp_e9_dta", 32'(dt_active), 32'h0);
      end
    end

    // Fault mid-pulse, ignored clear, then a valid clear and restart.
    dt_rise = 12'd2; dt_fall = 12'd2;
    pwm_in = 3'b001;
    tick(5);
    chk("fp_hs", 32'(hs_out), 32'h1);
    fault = 1'b1;
    tick(1);
    chk("ft_hs", 32'(hs_out), 32'h0);
    chk("ft_ls", 32'(ls_out), 32'h0);
    chk("ft_fl", 32'(fault_latched), 32'h1);
    fault_clr = 1'b1;
    tick(1);
    chk("ft_prio_fl", 32'(fault_latched), 32'h1);
    fault = 1'b0; fault_clr = 1'b0;
    tick(1);
    chk("ft_sticky", 32'(fault_latched), 32'h1);
    chk("ft_sticky_ls", 32'(ls_out), 32'h0);
    fault_clr = 1'b1;
    tick(1);
    chk("clr_fl", 32'(fault_latched), 32'h0);
    chk("clr_dta", 32'(dt_active), 32'h0);
    fault_clr = 1'b0;
    tick(1);
    chk("clr_e1_dta", 32'(dt_active), 32'h7);
    tick(1);
    chk("clr_e2_hs", 32'(hs_out), 32'h0);
    tick(1);
    chk("clr_e3_hs", 32'(hs_out), 32'h1);
    chk("clr_e3_ls", 32'(ls_out), 32'h6);

    // Enable drop and restart with per-direction times.
    en = 1'b0;
    tick(1);
    chk("en0_hs", 32'(hs_out), 32'h0);
    chk("en0_ls", 32'(ls_out), 32'h0);
    dt_rise = 12'd4; dt_fall = 12'd2;
    en = 1'b1;
    tick(1);
    chk("en1_dta", 32'(dt_active), 32'h7);
    tick(2);
    chk("en1_ls", 32'(ls_out), 32'h6);
    chk("en1_dta2", 32'(dt_active), 32'h1);
    tick(2);
    chk("en1_hs", 32'(hs_out), 32'h1);

    // Simultaneous opposite transitions; dt change after entry has no effect.
    pwm_in = 3'b110;
    tick(3);
    chk("mc_e2_dta", 32'(dt_active), 32'h7);
    chk("mc_e2_g", 32'({hs_out, ls_out}), 32'h0);
    dt_rise = 12'd9;
    tick(2);
    chk("mc_e4_ls", 32'(ls_out), 32'h1);
    chk("mc_e4_dta", 32'(dt_active), 32'h6);
    tick(2);
    chk("mc_e6_hs", 32'(hs_out), 32'h6);
    chk("mc_e6_dta", 32'(dt_active), 32'h0);

    // Reset mid-dead-interval, then reset clears the fault latch.
    pwm_in = 3'b000;
    tick(3);
    chk("rd_dta", 32'(dt_active), 32'h6);
    reset = 1'b1;
    tick(1);
    chk("rd_dta0", 32'(dt_active), 32'h0);
    chk("rd_g", 32'({hs_out, ls_out}), 32'h0);
    reset = 1'b0;
    fault = 1'b1;
    tick(1);
    fault = 1'b0;
    tick(1);
    chk("rf_fl", 32'(fault_latched), 32'h1);
    reset = 1'b1;
    tick(1);
    chk("rf_fl0", 32'(fault_latched), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
